// File: rtl/pc_unit.sv
// Program counter with stall-deferred redirects, exception entry and
// misaligned-target faulting. All state advances on the falling clock edge.
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h00400000,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h00400004,
  parameter int               STEP         = 4,
  parameter int               ALIGN_BITS   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             busy,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc_valid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             pending,
  output logic [WIDTH-1:0] epc,
  output logic             fault
);

  typedef enum logic {RUN, HOLD} state_t;

  localparam logic [WIDTH-1:0] ONES       = '1;
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(ONES << ALIGN_BITS);
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);

  state_t           state;
  logic [WIDTH-1:0] pend_target;
  logic             slot;
  logic [WIDTH-1:0] apply_target;
  logic             apply_redirect;
  logic             apply_misaligned;

  assign slot    = ena & ~busy;
  assign pc_plus = pc + STEP_W;
  assign pending = (state == HOLD);

  // A live redirect in a slot wins over whatever was parked in HOLD.
  always_comb begin
    apply_target     = redirect_valid ? redirect_target : pend_target;
    apply_redirect   = redirect_valid | (state == HOLD);
    apply_misaligned = |(apply_target & ALIGN_MASK);
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      pc          <= RESET_VECTOR;
      epc         <= '0;
      pend_target <= '0;
      fault       <= 1'b0;
      state       <= RUN;
    end else begin
      fault <= 1'b0;
      if (exc_valid) begin
        pc    <= EXC_VECTOR;
        epc   <= pc;
        state <= RUN;
      end else if (slot) begin
        state <= RUN;
        if (!apply_redirect) begin
          pc <= pc_plus;
        end else if (apply_misaligned) begin
          pc    <= EXC_VECTOR;
          epc   <= pc;
          fault <= 1'b1;
        end else begin
          pc <= apply_target;
        end
      end else if (redirect_valid) begin
        // Stalled: park the newest redirect until the next free slot.
        pend_target <= redirect_target;
        state       <= HOLD;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus pushes model predictions, a monitor
// on the rising edge pops and compares against the DUT outputs.
module tb_pc_unit;
  localparam logic [31:0] RV   = 32'h00400000;
  localparam logic [31:0] EV   = 32'h00400004;
  localparam logic [31:0] STEP = 32'd4;
  localparam logic [31:0] ALGN = 32'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1, ena = 1'b0, busy = 1'b0, redirect_valid = 1'b0, exc_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] pc, pc_plus, epc;
  logic        pending, fault;

  pc_unit dut (
    .clk(clk), .rst(rst), .ena(ena), .busy(busy),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .exc_valid(exc_valid), .pc(pc), .pc_plus(pc_plus), .pending(pending),
    .epc(epc), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        pending;
    logic        fault;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  logic [31:0] m_pc, m_epc, m_pt;
  bit          m_pend, m_fault;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: what the PC should be after the coming falling edge.
  task automatic cyc(input bit r, input bit e, input bit b, input bit rv,
                     input logic [31:0] rt, input bit x);
    logic [31:0] tgt;
    bit          jump;
    exp_t        ex;
    @(posedge clk);
    #1;
    rst = r; ena = e; busy = b; redirect_valid = rv; redirect_target = rt; exc_valid = x;
    if (r) begin
      m_pc = RV; m_epc = 0; m_pt = 0; m_pend = 0; m_fault = 0;
    end else begin
      m_fault = 0;
      if (x) begin
        m_epc = m_pc; m_pc = EV; m_pend = 0;
      end else if (e && !b) begin
        jump = rv || m_pend;
        tgt  = rv ? rt : m_pt;
        if (!jump) m_pc = m_pc + STEP;
        else if (tgt % ALGN != 0) begin
          m_epc = m_pc; m_pc = EV; m_fault = 1;
        end else m_pc = tgt;
        m_pend = 0;
      end else if (rv) begin
        m_pt = rt; m_pend = 1;
      end
    end
    ex.pc = m_pc; ex.epc = m_epc; ex.pending = m_pend; ex.fault = m_fault;
    q.push_back(ex);
  endtask

  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      if (q.size() > 0) begin
        ex = q.pop_front();
        chk("pc", pc, ex.pc);
        chk("epc", epc, ex.epc);
        chk("pending", {31'b0, pending}, {31'b0, ex.pending});
        chk("fault", {31'b0, fault}, {31'b0, ex.fault});
        chk("pc_plus", pc_plus, ex.pc + STEP);
      end
    end
  end

  initial begin
    logic [31:0] rt;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 32'h00400100, 1);
    // sequential run
    repeat (3) cyc(0, 1, 0, 0, 0, 0);
    // deferred redirect
    cyc(0, 1, 1, 1, 32'h00400100, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    // newest parked redirect wins
    cyc(0, 1, 1, 1, 32'h00400100, 0);
    cyc(0, 0, 0, 1, 32'h00400200, 0);
    cyc(0, 1, 0, 0, 0, 0);
    // misaligned live redirect faults for one cycle
    cyc(0, 1, 0, 1, 32'h00400010, 0);
    cyc(0, 1, 0, 1, 32'h00400102, 0);
    cyc(0, 1, 0, 0, 0, 0);
    // exception while stalled with a parked redirect
    cyc(0, 1, 0, 1, 32'h00400020, 0);
    cyc(0, 1, 1, 1, 32'h00400300, 0);
    cyc(0, 1, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0);
    // misaligned parked target faults when applied; exc suppresses fault
    cyc(0, 1, 1, 1, 32'h00400501, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 32'h00400503, 1);
    // live redirect overrides parked one
    cyc(0, 1, 1, 1, 32'h00400600, 0);
    cyc(0, 1, 0, 1, 32'h00400700, 0);
    // wraparound
    cyc(0, 1, 0, 1, 32'hFFFFFFFC, 0);
    cyc(0, 1, 0, 0, 0, 0);
    // reset during HOLD discards the parked redirect
    cyc(0, 1, 1, 1, 32'h00400800, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    repeat (400) begin
      rt = $urandom;
      if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
      cyc($urandom_range(0, 99) < 3, $urandom_range(0, 3) != 0,
          $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3, rt,
          $urandom_range(0, 99) < 5);
    end
    cyc(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning the PC and address width in bits.
REQ-002 The module SHALL have parameter RESET_VECTOR, default 32'h00400000, meaning the PC value after reset.
REQ-003 The module SHALL have parameter EXC_VECTOR, default 32'h00400004, meaning the exception and fault entry address.
REQ-004 The module SHALL have parameter STEP, default 4, meaning the sequential increment.
REQ-005 The module SHALL have parameter ALIGN_BITS, default 2, meaning the count of low target bits that must be zero.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the falling edge.
REQ-007 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The module SHALL have port ena, input, 1 bit: PC update enable.
REQ-009 The module SHALL have port busy, input, 1 bit: pipeline stall, which blocks update.
REQ-010 The module SHALL have port redirect_valid, input, 1 bit: branch or jump request.
REQ-011 The module SHALL have port redirect_target, input, WIDTH bits: the branch or jump destination.
REQ-012 The module SHALL have port exc_valid, input, 1 bit: exception request.
REQ-013 The module SHALL have port pc, output, WIDTH bits: the current PC, registered.
REQ-014 The module SHALL have port pc_plus, output, WIDTH bits: pc+STEP, combinational, mod 2^WIDTH.
REQ-015 The module SHALL have port pending, output, 1 bit: a captured redirect is waiting.
REQ-016 The module SHALL have port epc, output, WIDTH bits: the PC at the last exception or fault, registered.
REQ-017 The module SHALL have port fault, output, 1 bit: a one-cycle pulse on a misaligned redirect.

Function
REQ-018 The module SHALL hold internal state as two states, RUN (pending=0) and HOLD (pending=1), plus register pend_target[WIDTH].
REQ-019 An update slot SHALL be defined as ena=1 and busy=0 at a falling edge.
REQ-020 Per-edge priority SHALL be: rst > exc_valid > live redirect > pending redirect > sequential > hold.
REQ-021 exc_valid=1 SHALL act regardless of ena/busy: pc<=EXC_VECTOR, epc<=pc, pending<=0, state->RUN.
REQ-022 In an update slot with redirect_valid=1 and an aligned target, the module SHALL set pc<=redirect_target and pending<=0; the live redirect overrides any pending one.
REQ-023 In an update slot with redirect_valid=0 and pending=1, the module SHALL set pc<=pend_target, pending<=0, state HOLD->RUN.
REQ-024 In an update slot with no redirect and pending=0, the module SHALL set pc<=pc+STEP, truncated to WIDTH bits; 0xFFFFFFFC+4 wraps to 0x00000000.
REQ-025 redirect_valid=1 outside an update slot SHALL capture pend_target<=redirect_target and pending<=1 (RUN->HOLD); a later capture in HOLD overwrites it, newest wins; pc is unchanged.
REQ-026 Outside an update slot with no new redirect, the module SHALL hold pc, pending and pend_target.
REQ-027 A target is misaligned when its low ALIGN_BITS bits are nonzero; with ALIGN_BITS=0 no target is misaligned.
REQ-028 A misaligned live redirect in an update slot SHALL set pc<=EXC_VECTOR, epc<=pc, fault=1 for exactly one cycle, pending<=0.
REQ-029 A misaligned target SHALL still be captured into pending when not in an update slot; the fault is raised only when that pending target is applied, per REQ-028.
REQ-030 fault SHALL be 0 on every edge except one that applies a misaligned target; exc_valid on the same edge suppresses fault.
REQ-031 pc_plus SHALL follow pc combinationally with zero latency; pc, epc, pending and fault SHALL change only at falling edges.

Reset
REQ-032 rst=1 at a falling edge SHALL set pc=RESET_VECTOR, epc=0, pending=0, fault=0, pend_target=0 and state RUN, overriding all other inputs.
REQ-033 rst asserted mid-HOLD SHALL discard the pending redirect; the first update slot after reset release SHALL yield pc=RESET_VECTOR+STEP.

Verification
REQ-034 Reset, then 3 update slots SHALL give pc 0x00400000 -> 0x00400004 -> 0x00400008 -> 0x0040000C, with pc_plus always equal to pc+4.
REQ-035 busy=1 with redirect 0x00400100 SHALL set pending=1 with pc held; after busy=0, the next slot SHALL give pc=0x00400100 and pending=0.
REQ-036 While busy, redirects 0x00400100 then 0x00400200 SHALL give pc=0x00400200 in the first free slot, the newest target.
REQ-037 A redirect to 0x00400102 in a slot with pc=0x00400010 SHALL give pc=0x00400004, epc=0x00400010 and fault high for exactly one cycle.
REQ-038 exc_valid with busy=1, pending=1 and pc=0x00400020 SHALL give pc=0x00400004, epc=0x00400020, pending=0 and fault=0.
REQ-039 With pc=0xFFFFFFFC, one slot SHALL give pc=0x00000000; rst during HOLD SHALL give pc=0x00400000 and pending=0.
